spike_event_dispatcher: RTL
===========================

Name: spike_event_dispatcher

Overview:
- Upstream feeder of the synapse array.
- Accepts on/off spike events from a non-stallable event source (sensor/host) and buffers them in a FIFO.
- Broadcasts the events one at a time on the shared spike bus (valid/address/on_off), the spike_if master side that every synapse compares against its configured address.
- A programmable inter-event gap throttles the bus; overflow is flagged, never back-pressured.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 8, spike address width; matches synapse address field.
- GAP_W, 8, width of the inter-event gap configuration.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  event present this cycle; the source cannot be stalled
- in_address  in  ADDR_W  target synapse address
- in_on_off  in  1  1 = on (increment), 0 = off (decrement)
- enable  in  1  permits issue onto the spike bus
- gap_cycles  in  GAP_W  idle cycles inserted after each issued event
- ovf_clr  in  1  clears the sticky overflow flag
- spk_valid  out  1  spike bus valid, one-cycle pulse per event (spike_if master)
- spk_address  out  ADDR_W  spike bus address
- spk_on_off  out  1  spike bus polarity
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set when an event is dropped
- drop_count  out  16  dropped-event counter (only with the optional feature)

Behaviour:
- Reset:
  - FIFO pointers and level go to 0; state goes to IDLE; gap counter goes to 0.
  - spk_valid, spk_address, spk_on_off, overflow and drop_count all go to 0.
  - Reset mid-operation discards buffered events and any gap in progress.
- All outputs are registered.
- FIFO write:
  - Each entry is {in_address, in_on_off}.
  - On a clk edge with in_valid=1 and level<DEPTH, the event is written.
  - With in_valid=1 and level==DEPTH, the event is dropped and overflow is set. This holds even if a pop occurs on the same edge; full is judged on the pre-edge level.
- Overflow flag:
  - ovf_clr=1 clears overflow.
  - A drop on the same edge as ovf_clr takes priority: overflow stays 1.
- Level: incremented on write only, decremented on pop only, unchanged on simultaneous write and pop.
- State machine:
  - IDLE: if enable=1 and level>0, pop the head entry. Next cycle spk_valid=1 with that entry's address and polarity. Go to ISSUE.
  - ISSUE (one cycle, spk_valid high):
    - If gap_cycles==0, go to IDLE-equivalent evaluation immediately, so back-to-back issue is possible: one event per cycle while enable=1 and level>0.
    - Otherwise load the gap counter with gap_cycles and go to GAP.
  - GAP: decrement the counter each cycle; go to IDLE when it reaches 1. Exactly gap_cycles cycles pass with spk_valid=0.
  - gap_cycles is sampled when ISSUE is entered; changes during GAP do not affect the gap in progress.
- enable:
  - enable=0 blocks new pops only.
  - An ISSUE already in progress completes, and GAP keeps counting.
  - FIFO writes continue while enable=0.
- Bus outputs while spk_valid=0: spk_address=0 and spk_on_off=0.
- Latency: an event written on edge k into an empty FIFO, with IDLE and enable=1, appears with spk_valid=1 in the cycle after edge k+1 (2 cycles).
- Ordering: strict FIFO order; no coalescing of on/off pairs.
- Pointers: wrap modulo DEPTH.

Optional Feature:
- Macro: SPIKE_DISPATCH_DROP_CNT_EN.
- With the macro defined:
  - drop_count increments by 1 on each dropped event and saturates at 16'hffff.
  - ovf_clr also clears drop_count. A drop on the same edge as ovf_clr leaves drop_count=1.
- Without the macro: drop_count is tied to 0 and no counter logic is built.

Test Plan:
- Single event: reset, enable=1, gap=0, event (addr 8'h05, on) -> spk_valid one cycle, 2 cycles after the write, addr 5, on_off 1; level returns to 0.
- Burst with gap 0: 4 consecutive events (addr 1..4, alternating on/off) -> 4 consecutive spk_valid cycles in order with matching polarity.
- Gap 3: 3 events buffered -> spk_valid pulses separated by exactly 3 idle cycles. Changing gap to 0 mid-GAP does not shorten the current gap.
- Overflow: enable=0, DEPTH+2=18 events -> level=16, overflow=1, drop_count=2 (feature on). Enable -> exactly the first 16 events are issued. ovf_clr -> overflow=0, drop_count=0.
- Full with simultaneous pop: level=16, enable=1, write on the pop edge -> write dropped, overflow=1, level=15 afterwards.
- Reset mid-operation: assert reset during GAP with level=5 -> next cycle level=0, spk_valid=0, overflow=0; no stale event is issued after reset deasserts.

Source files
------------

// File: rtl/spike_event_dispatcher.sv
// spike_event_dispatcher
// Buffers on/off spike events from a source that cannot be stalled and
// broadcasts them one at a time on the shared spike bus (spike_if master).
// A programmable gap of idle cycles follows each issued event. When the FIFO
// is full, incoming events are dropped and a sticky overflow flag is raised.
// Optional feature: define SPIKE_DISPATCH_DROP_CNT_EN to build a saturating
// 16-bit dropped-event counter on drop_count (otherwise it is tied to 0).
module spike_event_dispatcher #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8,
  parameter int GAP_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_address,
  input  logic                     in_on_off,
  input  logic                     enable,
  input  logic [GAP_W-1:0]         gap_cycles,
  input  logic                     ovf_clr,
  output logic                     spk_valid,
  output logic [ADDR_W-1:0]        spk_address,
  output logic                     spk_on_off,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               spk_valid_q, spk_valid_d;
  logic [ADDR_W-1:0]  spk_address_q, spk_address_d;
  logic               spk_on_off_q, spk_on_off_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               full;
  logic               wr_en;
  logic               drop;
  logic               can_pop;
  logic               pop;
  logic [ENT_W-1:0]   head;

  // Full is judged on the pre-edge level, so a pop on the same edge never
  // makes room for the incoming event.
  assign full    = (level_q == LVL_W'(DEPTH));
  assign wr_en   = in_valid && !full;
  assign drop    = in_valid && full;
  assign can_pop = enable && (level_q != '0);
  assign head    = mem_q[rd_ptr_q];

  // Issue FSM: decides when to pop and sequences the inter-event gap. The
  // last GAP cycle behaves like IDLE so exactly gap_cycles idle cycles appear.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          state_d   = ISSUE;
          gap_cnt_d = gap_cycles;
        end
      end
      ISSUE: begin
        if (gap_cnt_q == '0) begin
          if (can_pop) begin
            pop       = 1'b1;
            state_d   = ISSUE;
            gap_cnt_d = gap_cycles;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          if (can_pop) begin
            pop       = 1'b1;
            state_d   = ISSUE;
            gap_cnt_d = gap_cycles;
          end else begin
            state_d   = IDLE;
            gap_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping, overflow flag and registered spike bus values.
  always_comb begin
    wr_ptr_d      = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d       = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    overflow_d    = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    spk_valid_d   = pop;
    spk_address_d = pop ? head[ENT_W-1:1] : '0;
    spk_on_off_d  = pop ? head[0] : 1'b0;
  end

  // State and control registers; reset discards buffered events and any gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      spk_valid_q   <= 1'b0;
      spk_address_q <= '0;
      spk_on_off_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      spk_valid_q   <= spk_valid_d;
      spk_address_q <= spk_address_d;
      spk_on_off_q  <= spk_on_off_d;
    end
  end

  // Event storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= {in_address, in_on_off};
    end
  end

`ifdef SPIKE_DISPATCH_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hffff)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0;
`endif

  assign spk_valid   = spk_valid_q;
  assign spk_address = spk_address_q;
  assign spk_on_off  = spk_on_off_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule
